// File: rtl/player_input_ctrl.sv
// rtl/player_input_ctrl.sv - debounced single-direction move command and movement tick for one player
module player_input_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         TICK_DIV        = 1_666_667,
  parameter logic [1:0] FACING_INIT     = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       enable,
  output logic       tick,
  output logic [3:0] move_dir,
  output logic [1:0] facing,
  output logic       moving
);

  // Button index order doubles as arbitration priority and facing code:
  // 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT (lower index wins).
  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(TICK_DIV - 1);

  logic [3:0]          raw;
  logic [3:0]          sync1;
  logic [3:0]          sync2;
  logic [3:0]          db;
  logic [3:0]          db_prev;
  logic [3:0][DBW-1:0] db_cnt;
  logic [3:0]          rise;

  logic [1:0]          lp;
  logic                lv;
  logic [1:0]          lp_next;
  logic                lv_next;
  logic [3:0]          dir_next;

  logic [TW-1:0]       tick_cnt;

  assign raw  = {btn_right, btn_left, btn_down, btn_up};
  assign rise = db & ~db_prev;

  // Highest-priority set bit of a button vector, UP first.
  function automatic logic [1:0] prio_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  // Two-flop synchronizer on every raw button line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db     <= 4'b0000;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Previous debounced level, used to find press edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= 4'b0000;
    end else begin
      db_prev <= db;
    end
  end

  // Last-pressed arbitration; the output stage uses the next-state value so a
  // debounced press shows up on move_dir one edge after it reaches db.
  always_comb begin
    lp_next = lp;
    lv_next = lv;
    if (|rise) begin
      lp_next = prio_idx(rise);
      lv_next = 1'b1;
    end else if (!(|db)) begin
      lv_next = 1'b0;
    end else if (lv && !db[lp]) begin
      lp_next = prio_idx(db);
    end else if (!lv) begin
      lp_next = prio_idx(db);
      lv_next = 1'b1;
    end
  end

  // One-hot command decode: bit3 UP .. bit0 RIGHT, gated by enable.
  always_comb begin
    dir_next = 4'b0000;
    if (enable && lv_next) begin
      dir_next = 4'b1000 >> lp_next;
    end
  end

  // Arbitration state keeps tracking even while enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp <= 2'd0;
      lv <= 1'b0;
    end else begin
      lp <= lp_next;
      lv <= lv_next;
    end
  end

  // Registered outputs; facing only follows a non-idle command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_dir <= 4'b0000;
      moving   <= 1'b0;
      facing   <= FACING_INIT;
    end else begin
      move_dir <= dir_next;
      moving   <= |dir_next;
      if (|dir_next) begin
        facing <= lp_next;
      end
    end
  end

  // Free-running tick divider, strobe registered on the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      if (tick_cnt == T_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      tick <= (tick_cnt == T_LAST);
    end
  end

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb/tb_player_input_ctrl.sv - directed table-driven bench for player_input_ctrl
module tb_player_input_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       enable;
  logic       tick;
  logic [3:0] move_dir;
  logic [1:0] facing;
  logic       moving;

  int applied = 0;
  int errors  = 0;
  int ecnt    = 0;

  // btn packs {up, down, left, right}; after n edges with these inputs expect dir/fac
  typedef struct {
    logic [3:0] btn;
    logic       en;
    int         n;
    logic [3:0] dir;
    logic [1:0] fac;
  } vec_t;

  vec_t vq[$];

  player_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(8),
    .FACING_INIT(2'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .enable(enable),
    .tick(tick),
    .move_dir(move_dir),
    .facing(facing),
    .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] b, input logic e, input int n,
                     input logic [3:0] d, input logic [1:0] f);
    vec_t v;
    v.btn = b;
    v.en  = e;
    v.n   = n;
    v.dir = d;
    v.fac = f;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [3:0] b, input logic e);
    {btn_up, btn_down, btn_left, btn_right} = b;
    enable = e;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %b, want %b", name, ecnt, act, exp);
    end
  endtask

  // One rising edge, then the tick strobe against the divider model.
  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
    check("tick", {3'b000, tick}, {3'b000, (ecnt % 8 == 0)});
  endtask

  task automatic check_outs(input string tag, input logic [3:0] d, input logic [1:0] f);
    check({tag, " move_dir"}, move_dir, d);
    check({tag, " moving"}, {3'b000, moving}, {3'b000, |d});
    check({tag, " facing"}, {2'b00, facing}, {2'b00, f});
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 4'b0000, 2'd1);
    check("reset tick", {3'b000, tick}, 4'b0000);

    // idle: ticks at 8, 16, 24
    add(4'b0000, 1, 24, 4'b0000, 2'd1);
    // UP press: 7-edge latency, then 7-edge release latency
    add(4'b1000, 1, 6, 4'b0000, 2'd1);
    add(4'b1000, 1, 1, 4'b1000, 2'd0);
    add(4'b1000, 1, 5, 4'b1000, 2'd0);
    add(4'b0000, 1, 6, 4'b1000, 2'd0);
    add(4'b0000, 1, 1, 4'b0000, 2'd0);
    add(4'b0000, 1, 4, 4'b0000, 2'd0);
    // 3-cycle RIGHT glitch is rejected
    add(4'b0001, 1, 3, 4'b0000, 2'd0);
    add(4'b0000, 1, 8, 4'b0000, 2'd0);
    // held RIGHT with a 2-cycle dropout
    add(4'b0001, 1, 6, 4'b0000, 2'd0);
    add(4'b0001, 1, 1, 4'b0001, 2'd3);
    add(4'b0001, 1, 4, 4'b0001, 2'd3);
    add(4'b0000, 1, 2, 4'b0001, 2'd3);
    add(4'b0001, 1, 1, 4'b0001, 2'd3);
    add(4'b0001, 1, 8, 4'b0001, 2'd3);
    add(4'b0000, 1, 6, 4'b0001, 2'd3);
    add(4'b0000, 1, 1, 4'b0000, 2'd3);
    // LEFT held, RIGHT overrides 20 cycles later, then falls back
    add(4'b0010, 1, 7, 4'b0010, 2'd2);
    add(4'b0010, 1, 13, 4'b0010, 2'd2);
    add(4'b0011, 1, 6, 4'b0010, 2'd2);
    add(4'b0011, 1, 1, 4'b0001, 2'd3);
    add(4'b0011, 1, 5, 4'b0001, 2'd3);
    add(4'b0010, 1, 6, 4'b0001, 2'd3);
    add(4'b0010, 1, 1, 4'b0010, 2'd2);
    add(4'b0000, 1, 7, 4'b0000, 2'd2);
    // UP and DOWN together: UP priority, then DOWN after UP release
    add(4'b1100, 1, 6, 4'b0000, 2'd2);
    add(4'b1100, 1, 1, 4'b1000, 2'd0);
    add(4'b0100, 1, 6, 4'b1000, 2'd0);
    add(4'b0100, 1, 1, 4'b0100, 2'd1);
    // enable gating while DOWN held
    add(4'b0100, 0, 1, 4'b0000, 2'd1);
    add(4'b0100, 0, 9, 4'b0000, 2'd1);
    add(4'b0100, 1, 1, 4'b0100, 2'd1);
    // LEFT pressed on top of DOWN wins as most recent
    add(4'b0110, 1, 6, 4'b0100, 2'd1);
    add(4'b0110, 1, 1, 4'b0010, 2'd2);

    rst  = 1'b0;
    ecnt = 0;
    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k].btn, vq[k].en);
      repeat (vq[k].n) step();
      check_outs($sformatf("vec%0d", k), vq[k].dir, vq[k].fac);
    end

    // async reset mid-hold clears outputs without a clock edge
    #2;
    rst = 1'b1;
    #1;
    check_outs("async rst", 4'b0000, 2'd1);
    check("async rst tick", {3'b000, tick}, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    ecnt = 0;
    // DOWN+LEFT still held: re-debounced from zero, DOWN wins the tie
    repeat (6) step();
    check_outs("post rst wait", 4'b0000, 2'd1);
    step();
    check_outs("post rst", 4'b0100, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
